data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/cpu_defs.sv | 20 ++
 rtl/dmarb_arbiter.sv | 21 ++
 rtl/data_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the data-memory arbiter: memory size, FSM encoding,
// port indices and a port-to-one-hot helper.
package cpu_defs;

  localparam int SIZE = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  function automatic logic [1:0] port_oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmarb_arbiter.sv
// Two-way combinational grant. With RR_EN a tie goes to the port not granted
// last (last_i); otherwise port 0 always wins.
module dmarb_arbiter #(
  parameter bit RR_EN = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  logic pick1;

  always_comb begin
    pick1 = 1'b0;
    gnt_o = 2'b00;
    if (req_i[0] && req_i[1]) pick1 = RR_EN && !last_i;
    else                      pick1 = req_i[1];
    if (|req_i) gnt_o = pick1 ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-cycle data memory, one transaction in
// flight. Define DATA_MEM_ARBITER_RR_EN for round-robin instead of fixed priority.
module data_mem_arbiter
  import cpu_defs::*;
#(
  parameter int MEM_BYTES = SIZE,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [1:0]        ReqValid,
  output logic [1:0]        ReqReady,
  input  logic [1:0]        ReqWrite,
  input  logic [ADDR_W-1:0] Req0Addr,
  input  logic [ADDR_W-1:0] Req1Addr,
  input  logic [DATA_W-1:0] Req0WData,
  input  logic [DATA_W-1:0] Req1WData,
  output logic [1:0]        RspValid,
  input  logic [1:0]        RspReady,
  output logic [DATA_W-1:0] RspRData,
  output logic              RspErr,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              Busy
);

  localparam logic [ADDR_W:0] ACC_BYTES = (ADDR_W+1)'(DATA_W / 8);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e            state_q;
  logic              port_q, write_q, busy_q;
  logic [1:0]        rsp_vld_q;
  logic [DATA_W-1:0] rsp_data_q, mem_wdata_q;
  logic              rsp_err_q, mem_rd_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [1:0]        gnt;
  logic              last_gnt, accept, sel, sel_wr, legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DATA_MEM_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
  logic last_gnt_q;
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)     last_gnt_q <= PORT_LDR;
    else if (accept) last_gnt_q <= sel;
  end
  assign last_gnt = last_gnt_q;
`else
  localparam bit RR_EN = 1'b0;
  assign last_gnt = PORT_LDR;
`endif

  dmarb_arbiter #(.RR_EN(RR_EN)) u_arb (
    .req_i  (ReqValid),
    .last_i (last_gnt),
    .gnt_o  (gnt)
  );

  assign accept    = (state_q == ST_IDLE) && (|gnt);
  assign sel       = gnt[1];
  assign sel_wr    = ReqWrite[sel];
  assign sel_addr  = sel ? Req1Addr : Req0Addr;
  assign sel_wdata = sel ? Req1WData : Req0WData;
  // Bound check done one bit wider so addresses near the top cannot wrap.
  assign legal     = (sel_addr[2:0] == 3'b000) && (({1'b0, sel_addr} + ACC_BYTES) <= MEM_LIMIT);

  assign ReqReady     = (accept && ResetN) ? gnt : 2'b00;
  assign RspValid     = rsp_vld_q;
  assign RspRData     = rsp_data_q;
  assign RspErr       = rsp_err_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemRead      = mem_rd_q;
  assign MemWrite     = mem_wr_q;
  assign Busy         = busy_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_CPU;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_vld_q   <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          port_q  <= sel;
          write_q <= sel_wr;
          busy_q  <= 1'b1;
          if (legal) begin
            state_q     <= ST_ACCESS;
            mem_rd_q    <= !sel_wr;
            mem_wr_q    <= sel_wr;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end else begin
            // Rejected accesses skip the memory entirely.
            state_q    <= ST_RESP;
            rsp_vld_q  <= port_oh(sel);
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        ST_ACCESS: begin
          state_q     <= ST_RESP;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          rsp_vld_q   <= port_oh(port_q);
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= write_q ? '0 : MemReadData;
        end
        ST_RESP: if (RspReady[port_q]) begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          rsp_vld_q  <= 2'b00;
          rsp_err_q  <= 1'b0;
          rsp_data_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
